// File: rtl/fault_recovery_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fault_recovery_sequencer
// Description : PC-checkpointing fault recovery FSM (flush, restore, retry, halt).
// Revision    : 1.0 - initial release
// ============================================================================
module fault_recovery_sequencer #(
  parameter int MAX_RETRY    = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        illegal_opcode,
  input  logic        invalid_control,
  input  logic        stuck_at_fault,
  input  logic        commit,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_saved,
  output logic        stall,
  output logic        insert_nop,
  output logic        retry_en,
  output logic        pc_restore,
  output logic        halted,
  output logic [1:0]  fault_cause,
  output logic [2:0]  retry_count,
  output logic [7:0]  fault_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLUSH   = 3'd1;
  localparam logic [2:0] S_RESTORE = 3'd2;
  localparam logic [2:0] S_RETRY   = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [2:0] C_MAX_RETRY  = 3'(MAX_RETRY);
  localparam logic [3:0] C_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [3:0]  r_flush_cnt;
  logic [31:0] r_pc_saved;
  logic [1:0]  r_fault_cause;
  logic [2:0]  r_retry_count;
  logic [7:0]  r_fault_count;

  logic        w_fault;
  logic [1:0]  w_cause;
  logic        w_fault_taken;
  logic        w_checkpoint;

  assign w_fault = illegal_opcode | invalid_control | stuck_at_fault;
  assign w_cause = stuck_at_fault  ? 2'd3 :
                   invalid_control ? 2'd2 :
                   illegal_opcode  ? 2'd1 : 2'd0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; stuck-at pre-empts everything outside HALT
  always_comb begin
    w_next_state  = r_state;
    w_fault_taken = 1'b0;
    w_checkpoint  = 1'b0;
    if (stuck_at_fault && (r_state != S_HALT)) begin
      w_next_state  = S_HALT;
      w_fault_taken = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fault) begin
            w_next_state  = S_FLUSH;
            w_fault_taken = 1'b1;
          end else if (commit) begin
            w_checkpoint = 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == C_FLUSH_LAST) begin
            w_next_state = S_RESTORE;
          end
        end
        S_RESTORE: w_next_state = S_RETRY;
        S_RETRY: begin
          if (w_fault) begin
            w_fault_taken = 1'b1;
            w_next_state  = (r_retry_count < C_MAX_RETRY) ? S_FLUSH : S_HALT;
          end else if (commit) begin
            w_next_state = S_IDLE;
            w_checkpoint = 1'b1;
          end
        end
        S_HALT:  w_next_state = S_HALT;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Datapath registers tracking the episode
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_cnt   <= 4'd0;
      r_pc_saved    <= 32'd0;
      r_fault_cause <= 2'd0;
      r_retry_count <= 3'd0;
      r_fault_count <= 8'd0;
    end else begin
      if ((r_state == S_FLUSH) && (w_next_state == S_FLUSH)) begin
        r_flush_cnt <= r_flush_cnt + 4'd1;
      end else begin
        r_flush_cnt <= 4'd0;
      end
      if (w_checkpoint) begin
        r_pc_saved <= pc_current;
      end
      if (w_fault_taken) begin
        r_fault_cause <= w_cause;
        if (r_fault_count != 8'hFF) begin
          r_fault_count <= r_fault_count + 8'd1;
        end
      end else if ((r_state == S_RETRY) && (w_next_state == S_IDLE)) begin
        r_fault_cause <= 2'd0;
      end
      if ((r_state == S_RESTORE) && (w_next_state == S_RETRY)) begin
        r_retry_count <= r_retry_count + 3'd1;
      end else if ((r_state == S_RETRY) && (w_next_state == S_IDLE)) begin
        r_retry_count <= 3'd0;
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    stall      = 1'b0;
    insert_nop = 1'b0;
    retry_en   = 1'b0;
    pc_restore = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_FLUSH: begin
        stall      = 1'b1;
        insert_nop = 1'b1;
      end
      S_RESTORE: begin
        stall      = 1'b1;
        pc_restore = 1'b1;
      end
      S_RETRY: retry_en = 1'b1;
      S_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_saved    = r_pc_saved;
  assign fault_cause = r_fault_cause;
  assign retry_count = r_retry_count;
  assign fault_count = r_fault_count;

endmodule
`default_nettype wire

// File: tb/tb_fault_recovery_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fault_recovery_sequencer
// Description : Directed bench with a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fault_recovery_sequencer;

  localparam int P_MAX_RETRY    = 3;
  localparam int P_FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        illegal_opcode = 1'b0;
  logic        invalid_control = 1'b0;
  logic        stuck_at_fault = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] pc_current = 32'd0;
  logic [31:0] pc_saved;
  logic        stall, insert_nop, retry_en, pc_restore, halted;
  logic [1:0]  fault_cause;
  logic [2:0]  retry_count;
  logic [7:0]  fault_count;

  int checks = 0;
  int failures = 0;

  fault_recovery_sequencer #(
    .MAX_RETRY    (P_MAX_RETRY),
    .FLUSH_CYCLES (P_FLUSH_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .illegal_opcode  (illegal_opcode),
    .invalid_control (invalid_control),
    .stuck_at_fault  (stuck_at_fault),
    .commit          (commit),
    .pc_current      (pc_current),
    .pc_saved        (pc_saved),
    .stall           (stall),
    .insert_nop      (insert_nop),
    .retry_en        (retry_en),
    .pc_restore      (pc_restore),
    .halted          (halted),
    .fault_cause     (fault_cause),
    .retry_count     (retry_count),
    .fault_count     (fault_count)
  );

  always #5 clk = ~clk;

  // Reference model: operating mode named by string, flush cycles left as a count
  string       m_mode = "IDLE";
  int          m_left = 0;
  int          m_retries = 0;
  int          m_faults = 0;
  int          m_cause = 0;
  logic [31:0] m_pc = 32'd0;

  always @(posedge clk) begin
    int f;
    int enc;
    f   = illegal_opcode || invalid_control || stuck_at_fault;
    enc = stuck_at_fault ? 3 : invalid_control ? 2 : illegal_opcode ? 1 : 0;
    if (reset) begin
      m_mode = "IDLE"; m_left = 0; m_retries = 0; m_faults = 0; m_cause = 0; m_pc = 0;
    end else if (stuck_at_fault && m_mode != "HALT") begin
      m_mode = "HALT"; m_cause = 3; m_faults = (m_faults < 255) ? m_faults + 1 : 255;
    end else if (m_mode == "IDLE") begin
      if (f != 0) begin
        m_mode = "FLUSH"; m_left = P_FLUSH_CYCLES; m_cause = enc;
        m_faults = (m_faults < 255) ? m_faults + 1 : 255;
      end else if (commit) m_pc = pc_current;
    end else if (m_mode == "FLUSH") begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = "RESTORE";
    end else if (m_mode == "RESTORE") begin
      m_retries = m_retries + 1; m_mode = "RETRY";
    end else if (m_mode == "RETRY") begin
      if (f != 0) begin
        m_faults = (m_faults < 255) ? m_faults + 1 : 255;
        m_cause = enc;
        if (m_retries < P_MAX_RETRY) begin
          m_mode = "FLUSH"; m_left = P_FLUSH_CYCLES;
        end else m_mode = "HALT";
      end else if (commit) begin
        m_mode = "IDLE"; m_retries = 0; m_cause = 0; m_pc = pc_current;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("stall",      32'(stall),      32'(m_mode == "FLUSH" || m_mode == "RESTORE" || m_mode == "HALT"));
    chk("insert_nop", 32'(insert_nop), 32'(m_mode == "FLUSH"));
    chk("pc_restore", 32'(pc_restore), 32'(m_mode == "RESTORE"));
    chk("retry_en",   32'(retry_en),   32'(m_mode == "RETRY"));
    chk("halted",     32'(halted),     32'(m_mode == "HALT"));
    chk("pc_saved",   pc_saved,        m_pc);
    chk("cause",      32'(fault_cause), 32'(m_cause));
    chk("retry_cnt",  32'(retry_count), 32'(m_retries));
    chk("fault_cnt",  32'(fault_count), 32'(m_faults));
  end

  task automatic step(input logic ill, input logic inv, input logic stk,
                      input logic cmt, input logic [31:0] pc);
    illegal_opcode  = ill;
    invalid_control = inv;
    stuck_at_fault  = stk;
    commit          = cmt;
    pc_current      = pc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("lit_reset_fc", 32'(fault_count), 32'd0);

    // Checkpoint 0x10
    step(0, 0, 0, 1, 32'h10);
    chk("lit_pc_10", pc_saved, 32'h10);
    step(0, 0, 0, 0, 32'h14);

    // Single illegal-opcode recovery episode
    step(1, 0, 0, 0, 32'h14);
    chk("lit_flush_nop", 32'(insert_nop), 32'd1);
    step(0, 0, 0, 0, 32'h14);
    step(0, 0, 0, 0, 32'h14);
    chk("lit_restore", 32'(pc_restore), 32'd1);
    step(0, 0, 0, 0, 32'h14);
    chk("lit_retry_cnt1", 32'(retry_count), 32'd1);
    chk("lit_cause1", 32'(fault_cause), 32'd1);
    step(0, 0, 0, 1, 32'h10);
    chk("lit_fc1", 32'(fault_count), 32'd1);
    chk("lit_rc0", 32'(retry_count), 32'd0);

    // Fault and commit together in IDLE: fault wins
    step(1, 0, 0, 1, 32'h20);
    chk("lit_pc_kept", pc_saved, 32'h10);
    chk("lit_flush_enter", 32'(insert_nop), 32'd1);
    // Stuck-at during FLUSH
    step(0, 0, 1, 0, 32'h20);
    chk("lit_halt", 32'(halted), 32'd1);
    chk("lit_cause3", 32'(fault_cause), 32'd3);
    step(0, 1, 0, 1, 32'h24);
    step(0, 0, 0, 0, 32'h24);
    do_reset();
    chk("lit_reset_fc2", 32'(fault_count), 32'd0);

    // Persistent invalid_control: three retries then HALT
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 32'h30);
    chk("lit_halt_inv", 32'(halted), 32'd1);
    chk("lit_fc4", 32'(fault_count), 32'd4);
    chk("lit_rc3", 32'(retry_count), 32'd3);
    do_reset();

    // Saturate fault_count with single-fault episodes
    for (int e = 0; e < 255; e++) begin
      step(1, 0, 0, 0, 32'h40);
      step(0, 0, 0, 0, 32'h40);
      step(0, 0, 0, 0, 32'h40);
      step(0, 0, 0, 0, 32'h40);
      step(0, 0, 0, 1, 32'h44);
    end
    chk("lit_fc255", 32'(fault_count), 32'd255);
    step(0, 1, 0, 0, 32'h48);
    chk("lit_fc_sat", 32'(fault_count), 32'd255);
    step(0, 0, 0, 0, 32'h48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
